// File: rtl/mips_regfile_if.sv
// Register-file bus: write port, two read ports and the serial dump stream.
// The requester (CPU side or bench) uses master; the register file uses slave.
interface mips_regfile_if #(
  parameter int DATA_W = 32
);
  logic              we;
  logic [4:0]        wa;
  logic [DATA_W-1:0] wd;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              dump_req;
  logic              dump_valid;
  logic [4:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              busy;

  modport master (
    output we, wa, wd, ra1, ra2, dump_req,
    input  rd1, rd2, dump_valid, dump_idx, dump_data, dump_last, busy
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, dump_req,
    output rd1, rd2, dump_valid, dump_idx, dump_data, dump_last, busy
  );
endinterface

// File: rtl/mips_regfile.sv
// MIPS-style register file: r0 hardwired to zero, two bypassed combinational
// read ports, and a serial dump engine that walks all registers once per request.
module mips_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input logic           clk,
  input logic           rst,
  mips_regfile_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_t;

  logic [DATA_W-1:0] r_regs [NREGS];
  state_t            r_state, w_state_nx;
  logic [4:0]        r_dump_idx, w_dump_idx_nx, w_idx_inc;
  logic [DATA_W-1:0] r_dump_data, w_dump_data_nx;
  logic              w_wr;

  assign w_wr      = bus.we && (bus.wa != 5'd0);
  assign w_idx_inc = r_dump_idx + 5'd1;

  // r_regs[0] is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  assign bus.rd1 = (bus.ra1 == 5'd0)                ? '0     :
                   (bus.we && (bus.wa == bus.ra1))  ? bus.wd :
                                                      r_regs[bus.ra1];
  assign bus.rd2 = (bus.ra2 == 5'd0)                ? '0     :
                   (bus.we && (bus.wa == bus.ra2))  ? bus.wd :
                                                      r_regs[bus.ra2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dump_idx  <= '0;
      r_dump_data <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_dump_idx  <= w_dump_idx_nx;
      r_dump_data <= w_dump_data_nx;
    end
  end

  // Dump data is taken from storage as held before the edge, so a write on
  // the same edge is not reflected in the dumped value.
  always_comb begin
    w_state_nx     = r_state;
    w_dump_idx_nx  = r_dump_idx;
    w_dump_data_nx = r_dump_data;
    case (r_state)
      IDLE: begin
        if (bus.dump_req) begin
          w_state_nx     = DUMP;
          w_dump_idx_nx  = '0;
          w_dump_data_nx = '0;
        end
      end
      DUMP: begin
        if (r_dump_idx != 5'd31) begin
          w_dump_idx_nx  = w_idx_inc;
          w_dump_data_nx = r_regs[w_idx_inc];
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.busy       = (r_state == DUMP);
  assign bus.dump_valid = (r_state == DUMP);
  assign bus.dump_idx   = r_dump_idx;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_last  = (r_state == DUMP) && (r_dump_idx == 5'd31);
endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: a reference register model for reads and a queue of
// expected dump beats, popped by a monitor on every valid dump cycle.
module tb_mips_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_regfile_if #(.DATA_W(32)) bus ();

  mips_regfile #(.DATA_W(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } dent_t;

  dent_t       exp_q[$];
  logic [31:0] m [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.wa = a; bus.wd = d;
    tick();
    if (a != 5'd0) m[a] = d;
    bus.we = 1'b0;
  endtask

  // Monitor: every valid dump beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.dump_valid) begin
      if (exp_q.size() == 0) begin
        chk("dump_extra", 32'd1, 32'd0);
      end else begin
        dent_t e;
        e = exp_q.pop_front();
        chk("dump_idx",  {27'd0, bus.dump_idx}, {27'd0, e.idx});
        chk("dump_data", bus.dump_data, e.data);
        chk("dump_last", {31'd0, bus.dump_last}, {31'd0, e.last});
        chk("dump_busy", {31'd0, bus.busy}, 32'd1);
      end
    end
  end

  // Runs one complete dump. An optional write is driven while index k is on
  // the outputs; it lands on the edge that presents k+1, so only beats k+2
  // and later can observe it.
  task automatic do_dump(input bit wen, input int k, input logic [4:0] r,
                         input logic [31:0] d, input int hold);
    int cyc;
    for (int j = 0; j < 32; j++) begin
      dent_t e;
      e.idx  = 5'(j);
      e.data = m[j];
      if (wen && (j == int'(r)) && (j >= k + 2)) e.data = d;
      e.last = (j == 31);
      exp_q.push_back(e);
    end
    bus.dump_req = 1'b1;
    tick();
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      bus.dump_req = (cyc < hold) || (cyc == 31);
      if (wen && cyc == k) begin
        bus.we = 1'b1; bus.wa = r; bus.wd = d;
      end
      tick();
      if (wen && cyc == k) begin
        m[r] = d;
        bus.we = 1'b0;
      end
      cyc++;
    end
    bus.dump_req = 1'b0;
    chk("dump_cycles", 32'(cyc), 32'd32);
    chk("dump_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("no_restart", {31'd0, bus.busy}, 32'd0);
    chk("valid_after", {31'd0, bus.dump_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.ra1 = 5'd5; bus.ra2 = 5'd31; bus.dump_req = 1'b0;
    #3;
    chk("rst_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("rst_idx",   {27'd0, bus.dump_idx}, 32'd0);
    chk("rst_data",  bus.dump_data, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_rd1",   bus.rd1, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Write then read
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    bus.ra1 = 5'd5; bus.ra2 = 5'd31; #1;
    chk("rd1_r5",  bus.rd1, m[5]);
    chk("rd2_r31", bus.rd2, m[31]);

    // Register 0 ignores writes, both during and after the write cycle
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; bus.ra1 = 5'd0; #1;
    chk("r0_same", bus.rd1, 32'd0);
    tick();
    bus.we = 1'b0; #1;
    chk("r0_after", bus.rd1, 32'd0);

    // Same-cycle bypass on both ports
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hA5A5A5A5;
    bus.ra1 = 5'd7; bus.ra2 = 5'd7; #1;
    chk("byp_rd1", bus.rd1, 32'hA5A5A5A5);
    chk("byp_rd2", bus.rd2, 32'hA5A5A5A5);
    tick();
    m[7] = 32'hA5A5A5A5;
    bus.we = 1'b0; #1;
    chk("byp_held", bus.rd1, m[7]);

    // Full dump; dump_req held a few cycles into it and high on the final edge
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    do_dump(1'b0, 0, 5'd0, 32'd0, 3);

    // Writes during a dump: one visible later, one on the same edge not visible
    do_dump(1'b1, 3, 5'd10, 32'hCAFEF00D, 0);
    do_dump(1'b1, 3, 5'd4, 32'hBADC0FFE, 0);
    bus.ra1 = 5'd4; bus.ra2 = 5'd10; #1;
    chk("rd_r4_post",  bus.rd1, 32'hBADC0FFE);
    chk("rd_r10_post", bus.rd2, 32'hCAFEF00D);

    // Reset mid-dump at index 12
    for (int j = 0; j <= 12; j++) begin
      dent_t e;
      e.idx = 5'(j); e.data = m[j]; e.last = 1'b0;
      exp_q.push_back(e);
    end
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    @(negedge clk); #1;
    chk("mid_left", 32'(exp_q.size()), 32'd0);
    chk("mid_idx",  {27'd0, bus.dump_idx}, 32'd12);
    rst = 1'b1; #1;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    chk("mid_valid", {31'd0, bus.dump_valid}, 32'd0);
    chk("mid_busy",  {31'd0, bus.busy}, 32'd0);
    chk("mid_last",  {31'd0, bus.dump_last}, 32'd0);
    chk("mid_didx",  {27'd0, bus.dump_idx}, 32'd0);
    for (int i = 1; i < 32; i += 6) begin
      bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i); #1;
      chk("mid_rd1", bus.rd1, 32'd0);
      chk("mid_rd2", bus.rd2, 32'd0);
    end

    // Bypass stays live in reset, but the write itself is dropped
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h55AA55AA; bus.ra1 = 5'd3; #1;
    chk("rst_byp", bus.rd1, 32'h55AA55AA);
    tick();
    bus.we = 1'b0; #1;
    chk("rst_wr_drop", bus.rd1, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // First write after release is accepted, then a fresh dump from index 0
    wr(5'd9, 32'h0BADF00D);
    bus.ra1 = 5'd9; #1;
    chk("first_wr", bus.rd1, 32'h0BADF00D);
    do_dump(1'b0, 0, 5'd0, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
